// File: rtl/pc_gen_unit_if.sv
// Fetch PC generator bus: execute-stage redirect request in, fetch PC and
// status out. The master side is the execute/control logic, the slave side
// is the PC generator.
interface pc_gen_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             redirect_valid;
  logic [2:0]       pcn_control;
  logic             br_taken;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  trap_vec;
  logic [XLEN-1:0]  mepc;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus_step;
  logic             flush;
  logic             misalign;
  logic [XLEN-1:0]  misalign_addr;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output stall, redirect_valid, pcn_control, br_taken, ex_pc, imm, rs1,
           trap_vec, mepc,
    input  pc, pc_plus_step, flush, misalign, misalign_addr, redirect_cnt
  );

  modport slave (
    input  stall, redirect_valid, pcn_control, br_taken, ex_pc, imm, rs1,
           trap_vec, mepc,
    output pc, pc_plus_step, flush, misalign, misalign_addr, redirect_cnt
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: registered fetch PC, sequential advance, redirects
// from execute (branch/JAL/JALR/trap/MRET) that override stall, misaligned
// target detection, a one-cycle flush pulse and a wrapping redirect counter.
module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              STEP         = 4,
  parameter int              CNT_W        = 16
) (
  input logic          clk,
  input logic          rst_n,
  pc_gen_unit_if.slave bus
);

  localparam logic [2:0] MODE_BRANCH = 3'd1;
  localparam logic [2:0] MODE_JAL    = 3'd2;
  localparam logic [2:0] MODE_JALR   = 3'd3;
  localparam logic [2:0] MODE_TRAP   = 3'd4;
  localparam logic [2:0] MODE_MRET   = 3'd5;

  // STEP is a power of two, so "target mod STEP" is just the low bits.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] JALR_MASK  = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  pc_plus_step_s;
  logic [XLEN-1:0]  target_s;
  logic             req_s;
  logic             target_misaligned_s;

  assign pc_plus_step_s = pc_q + XLEN'(STEP);

  // Decode the control-transfer mode into a target address and a request.
  always_comb begin
    target_s = pc_plus_step_s;
    req_s    = 1'b0;
    case (bus.pcn_control)
      MODE_BRANCH: begin
        target_s = bus.ex_pc + bus.imm;
        req_s    = bus.redirect_valid & bus.br_taken;
      end
      MODE_JAL: begin
        target_s = bus.ex_pc + bus.imm;
        req_s    = bus.redirect_valid;
      end
      MODE_JALR: begin
        target_s = (bus.rs1 + bus.imm) & JALR_MASK;
        req_s    = bus.redirect_valid;
      end
      MODE_TRAP: begin
        target_s = {bus.trap_vec[XLEN-1:2], 2'b00};
        req_s    = bus.redirect_valid;
      end
      MODE_MRET: begin
        target_s = bus.mepc;
        req_s    = bus.redirect_valid;
      end
      default: begin
        // SEQ and reserved encodings never redirect.
        target_s = pc_plus_step_s;
        req_s    = 1'b0;
      end
    endcase
  end

  // Trap entry is word-aligned by construction; everything else is checked.
  always_comb begin
    if (bus.pcn_control == MODE_TRAP) begin
      target_misaligned_s = 1'b0;
    end else begin
      target_misaligned_s = |(target_s & ALIGN_MASK);
    end
  end

  // Next-state selection: redirect beats stall, stall beats sequential.
  always_comb begin
    pc_d            = pc_q;
    flush_d         = 1'b0;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    cnt_d           = cnt_q;
    if (req_s && !target_misaligned_s) begin
      pc_d    = target_s;
      flush_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (req_s) begin
      // Hold the PC and report; the controller follows up with a TRAP.
      misalign_d      = 1'b1;
      misalign_addr_d = target_s;
      flush_d         = 1'b1;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus_step_s;
    end
  end

  // State registers with asynchronous reset to the reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_VECTOR;
      flush_q         <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      cnt_q           <= '0;
    end else begin
      pc_q            <= pc_d;
      flush_q         <= flush_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      cnt_q           <= cnt_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus_step  = pc_plus_step_s;
  assign bus.flush         = flush_q;
  assign bus.misalign      = misalign_q;
  assign bus.misalign_addr = misalign_addr_q;
  assign bus.redirect_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: a driver issues directed and random
// redirect/stall stimulus and pushes the reference-model expectation; a
// monitor pops one expectation per clock and compares all outputs.
module tb_pc_gen_unit;
  localparam int              XLEN  = 32;
  localparam logic [31:0]     RV    = 32'h0000_0100;
  localparam int              STEP  = 4;
  localparam int              CNT_W = 4;
  localparam longint unsigned MOD   = 64'h1_0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic [31:0] addr;
    logic [3:0]  cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  pc_gen_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pc_gen_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .STEP(STEP), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  // reference model state
  longint unsigned m_pc, m_addr;
  int              m_cnt;
  bit              m_flush, m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_addr = 0; m_cnt = 0; m_flush = 0; m_mis = 0;
  endtask

  // Behavioural rules: pick a target, decide redirect, then update.
  task automatic model_step(input bit st, input bit rv, input int mode, input bit bt,
                            input longint unsigned ex, input longint unsigned im,
                            input longint unsigned r1, input longint unsigned tv,
                            input longint unsigned ep);
    longint unsigned tgt;
    bit req;
    bit bad;
    tgt = 0; req = 0;
    if (mode == 1)      begin tgt = (ex + im) % MOD; req = rv && bt; end
    else if (mode == 2) begin tgt = (ex + im) % MOD; req = rv; end
    else if (mode == 3) begin tgt = (r1 + im) % MOD; tgt = tgt - (tgt % 2); req = rv; end
    else if (mode == 4) begin tgt = tv - (tv % 4); req = rv; end
    else if (mode == 5) begin tgt = ep; req = rv; end
    bad = (mode != 4) && ((tgt % STEP) != 0);
    if (req && !bad) begin
      m_pc = tgt; m_flush = 1; m_mis = 0; m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else if (req) begin
      m_flush = 1; m_mis = 1; m_addr = tgt;
    end else begin
      m_flush = 0; m_mis = 0;
      if (!st) m_pc = (m_pc + STEP) % MOD;
    end
  endtask

  // Called at a negedge: apply inputs, push expectation, move to next negedge.
  task automatic drive(input bit st, input bit rv, input int mode, input bit bt,
                       input logic [31:0] ex, input logic [31:0] im, input logic [31:0] r1,
                       input logic [31:0] tv, input logic [31:0] ep);
    exp_t e;
    bus.stall = st; bus.redirect_valid = rv; bus.pcn_control = 3'(mode);
    bus.br_taken = bt; bus.ex_pc = ex; bus.imm = im; bus.rs1 = r1;
    bus.trap_vec = tv; bus.mepc = ep;
    model_step(st, rv, mode, bt, ex, im, r1, tv, ep);
    e.pc = 32'(m_pc); e.flush = m_flush; e.mis = m_mis; e.addr = 32'(m_addr);
    e.cnt = 4'(m_cnt);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input bit st);
    drive(st, 1'b0, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc", bus.pc, e.pc);
        check("pc_plus_step", bus.pc_plus_step, e.pc + 32'd4);
        check("flush", {31'd0, bus.flush}, {31'd0, e.flush});
        check("misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
        check("misalign_addr", bus.misalign_addr, e.addr);
        check("redirect_cnt", {28'd0, bus.redirect_cnt}, {28'd0, e.cnt});
      end
    end
  end

  initial begin
    logic [31:0] ex, im, r1, tv, ep;
    int mode;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.pcn_control = 3'd0;
    bus.br_taken = 1'b0; bus.ex_pc = '0; bus.imm = '0; bus.rs1 = '0;
    bus.trap_vec = '0; bus.mepc = '0;
    model_reset();
    #12;
    check("reset_pc", bus.pc, RV);
    check("reset_flush", {31'd0, bus.flush}, 32'd0);
    check("reset_cnt", {28'd0, bus.redirect_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // sequential after reset: 104, 108, 10c
    repeat (3) idle(1'b0);
    // MRET to 0x200, stall three cycles, then advance
    drive(1'b0, 1'b1, 5, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h200);
    repeat (3) idle(1'b1);
    idle(1'b0);
    // taken branch to 0x30, then same branch not taken
    drive(1'b0, 1'b1, 1, 1'b1, 32'h40, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 1, 1'b0, 32'h40, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0);
    // misaligned JALR then TRAP
    drive(1'b0, 1'b1, 3, 1'b0, 32'h0, 32'h0, 32'h1003, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 4, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_0003, 32'h0);
    idle(1'b0);
    // JAL under stall, then back-to-back MRET
    drive(1'b1, 1'b1, 2, 1'b0, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 5, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h500);
    // reserved modes and valid-low redirects do nothing special
    drive(1'b0, 1'b1, 6, 1'b1, 32'h0, 32'h3, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 2, 1'b1, 32'h0, 32'h3, 32'h0, 32'h0, 32'h0);
    // PC wrap at the top of the address space
    drive(1'b0, 1'b1, 5, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    idle(1'b0);
    idle(1'b0);

    // randomized traffic: stall, modes, alignment mixes; counter wraps often
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 7);
      ex = $urandom; ex[1:0] = 2'b00;
      im = $urandom;
      if ($urandom_range(0, 2) != 0) im[1:0] = 2'b00;
      r1 = $urandom; tv = $urandom; ep = $urandom;
      if ($urandom_range(0, 3) != 0) ep[1:0] = 2'b00;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), mode,
            1'($urandom_range(0, 1)), ex, im, r1, tv, ep);
    end

    // asynchronous reset mid-cycle, after the last expectation is consumed
    idle(1'b0);
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_pc", bus.pc, RV);
    check("async_reset_cnt", {28'd0, bus.redirect_cnt}, 32'd0);
    check("async_reset_flush", {31'd0, bus.flush}, 32'd0);
    check("async_reset_misalign", {31'd0, bus.misalign}, 32'd0);
    check("async_reset_addr", bus.misalign_addr, 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold_pc", bus.pc, RV);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) idle(1'b0);
    drive(1'b0, 1'b1, 2, 1'b0, 32'h1000, 32'h10, 32'h0, 32'h0, 32'h0);
    idle(1'b0);

    @(posedge clk);
    #3;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
